// File: rtl/edge_detect_multi.sv
// Per-channel synchronise, debounce and edge-pulse for asynchronous board inputs.
// Latency: input stable before edge 1 -> level/p/any update at edge SYNC_STAGES+DEBOUNCE_CYCLES.
// Backpressure: none; p/any are single-cycle events with no handshake.
module edge_detect_multi #(
    parameter int N               = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] a,
    input  logic [1:0]   mode,
    output logic [N-1:0] level,
    output logic [N-1:0] p,
    output logic         any
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    // Stage 0 takes the raw input; stage SYNC_STAGES-1 is the synchronised value.
    logic [SYNC_STAGES-1:0][N-1:0] sync_q;
    logic [N-1:0]                  s;
    logic [N-1:0][CW-1:0]          cnt_q;
    logic [N-1:0][CW-1:0]          cnt_d;
    logic [N-1:0]                  level_d;
    logic [N-1:0]                  p_d;

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        cnt_d   = cnt_q;
        level_d = level;
        for (int i = 0; i < N; i++) begin
            if (s[i] == level[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                level_d[i] = s[i];
                cnt_d[i]   = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
        // Pulses come from the level transition itself, so mode only matters at the accept edge.
        p_d = (level_d & ~level & {N{mode[0]}}) |
              (~level_d & level & {N{mode[1]}});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            cnt_q  <= '0;
            level  <= '0;
            p      <= '0;
            any    <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], a};
            cnt_q  <= cnt_d;
            level  <= level_d;
            p      <= p_d;
            any    <= |p_d;
        end
    end

endmodule

// File: tb/tb_edge_detect_multi.sv
// Self-checking bench for edge_detect_multi: default build against a windowed reference model, plus an N=1/SYNC=3/DEBOUNCE=1 build.
module tb_edge_detect_multi;
    localparam int N = 8;
    localparam int S = 2;
    localparam int D = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst  = 1'b1;
    logic [N-1:0] a    = '0;
    logic [1:0]   mode = 2'b00;
    logic [N-1:0] level;
    logic [N-1:0] p;
    logic         any;

    logic         rst2  = 1'b1;
    logic [0:0]   a2    = 1'b0;
    logic [1:0]   mode2 = 2'b01;
    logic [0:0]   level2;
    logic [0:0]   p2;
    logic         any2;

    edge_detect_multi #(.N(N), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .rst(rst), .a(a), .mode(mode), .level(level), .p(p), .any(any)
    );

    edge_detect_multi #(.N(1), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(1)) dut2 (
        .clk(clk), .rst(rst2), .a(a2), .mode(mode2), .level(level2), .p(p2), .any(any2)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a level flips once the synchronised input (raw input S edges
    // earlier) has disagreed with it on each of the last D post-reset edges.
    int           cyc      = 0;
    int           last_rst = -1000;
    logic [N-1:0] hist [256];
    logic [N-1:0] m_level  = '0;
    logic [N-1:0] m_p      = '0;
    logic         m_any    = 1'b0;

    function automatic logic [N-1:0] s_at(input int k);
        if (k - S < 0 || k - S <= last_rst) return '0;
        return hist[(k - S) % 256];
    endfunction

    function automatic logic [N-1:0] model_next_level(input int k);
        logic [N-1:0] nl;
        logic [N-1:0] sv;
        nl = m_level;
        for (int i = 0; i < N; i++) begin
            bit stable_diff;
            stable_diff = (k - D + 1 > last_rst);
            for (int t = k - D + 1; t <= k; t++) begin
                sv = s_at(t);
                if (sv[i] === m_level[i]) stable_diff = 1'b0;
            end
            if (stable_diff) nl[i] = ~m_level[i];
        end
        return nl;
    endfunction

    function automatic logic [N-1:0] model_pulses(input logic [N-1:0] nl);
        return (nl & ~m_level & {N{mode[0]}}) | (~nl & m_level & {N{mode[1]}});
    endfunction

    always @(posedge clk) begin
        hist[cyc % 256] <= a;
        cyc <= cyc + 1;
        if (rst) begin
            last_rst <= cyc;
            m_level  <= '0;
            m_p      <= '0;
            m_any    <= 1'b0;
        end else begin
            m_level <= model_next_level(cyc);
            m_p     <= model_pulses(model_next_level(cyc));
            m_any   <= |model_pulses(model_next_level(cyc));
        end
    end

    // Observation state accumulated while the clock advances.
    int           obs_pulse [N];
    int           obs_any;
    int           mism;
    int           consec;
    int           bad_cyc;
    logic [N-1:0] any_p;
    logic [N-1:0] prev_p = '0;
    logic [N-1:0] bad_p, bad_mp, bad_l, bad_ml;

    task automatic clear_obs();
        for (int i = 0; i < N; i++) obs_pulse[i] = 0;
        obs_any = 0;
        mism    = 0;
        consec  = 0;
        any_p   = '0;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) if (p[i] === 1'b1) obs_pulse[i]++;
            if (any === 1'b1) begin
                obs_any++;
                any_p = p;
            end
            if ((p & prev_p) !== '0) consec++;
            prev_p = p;
            if (p !== m_p || level !== m_level || any !== m_any) begin
                if (mism == 0) begin
                    bad_cyc = cyc; bad_p = p; bad_mp = m_p; bad_l = level; bad_ml = m_level;
                end
                mism++;
            end
        end
    endtask

    task automatic test_reset();
        a = '1; mode = 2'b01; rst = 1'b1;
        clear_obs();
        repeat (3) begin
            @(negedge clk);
            n_checks++;
            if ({level, p, any} !== '0) begin
                n_fail++; $display("FAIL reset_hold: level/p/any=%b expected all 0", {level, p, any});
            end
        end
        rst = 1'b0;
        clear_obs();
        run(5);
        n_checks++;
        if (obs_any !== 0 || level !== 8'h00) begin
            n_fail++; $display("FAIL reset_early: any cycles=%0d level=%h expected 0 and 00", obs_any, level);
        end
        run(1);
        n_checks++;
        if (p !== 8'hFF || any !== 1'b1 || level !== 8'hFF) begin
            n_fail++; $display("FAIL reset_edge6: p=%h any=%b level=%h expected ff 1 ff", p, any, level);
        end
        run(1);
        n_checks++;
        if (p !== 8'h00 || any !== 1'b0) begin
            n_fail++; $display("FAIL reset_width: p=%h any=%b expected 00 0", p, any);
        end
        run(6);
        n_checks++;
        if (level !== 8'hFF || obs_any !== 1 || mism !== 0) begin
            n_fail++; $display("FAIL reset_after: level=%h any cycles=%0d model diffs=%0d expected ff 1 0", level, obs_any, mism);
        end
    endtask

    task automatic test_latency();
        a = '0; mode = 2'b01; rst = 1'b1;
        run(2);
        rst = 1'b0;
        run(10);
        clear_obs();
        a[0] = 1'b1;
        run(5);
        n_checks++;
        if (obs_pulse[0] !== 0 || level[0] !== 1'b0) begin
            n_fail++; $display("FAIL latency_early: pulses=%0d level0=%b expected 0 0", obs_pulse[0], level[0]);
        end
        run(1);
        n_checks++;
        if (p !== 8'h01 || level[0] !== 1'b1) begin
            n_fail++; $display("FAIL latency_edge6: p=%h level0=%b expected 01 1", p, level[0]);
        end
        run(1);
        n_checks++;
        if (p[0] !== 1'b0) begin
            n_fail++; $display("FAIL latency_width: p0=%b expected 0", p[0]);
        end
        run(10);
        n_checks++;
        if (obs_pulse[0] !== 1 || mism !== 0) begin
            n_fail++; $display("FAIL latency_hold: pulses=%0d model diffs=%0d expected 1 0", obs_pulse[0], mism);
        end
    endtask

    task automatic test_glitch();
        clear_obs();
        a[3] = 1'b1; run(3);
        a[3] = 1'b0; run(12);
        n_checks++;
        if (obs_pulse[3] !== 0 || level[3] !== 1'b0) begin
            n_fail++; $display("FAIL glitch_reject: pulses=%0d level3=%b expected 0 0", obs_pulse[3], level[3]);
        end
        a[3] = 1'b1; run(12);
        n_checks++;
        if (obs_pulse[3] !== 1 || level[3] !== 1'b1) begin
            n_fail++; $display("FAIL glitch_accept: pulses=%0d level3=%b expected 1 1", obs_pulse[3], level[3]);
        end
        a[3] = 1'b0; run(12);
        n_checks++;
        if (mism !== 0) begin
            n_fail++; $display("FAIL glitch_model: %0d diffs, first cyc %0d p=%h exp %h level=%h exp %h",
                               mism, bad_cyc, bad_p, bad_mp, bad_l, bad_ml);
        end
    endtask

    task automatic test_modes();
        logic [1:0] modes [4];
        int         exp_pulses [4];
        modes      = '{2'b01, 2'b10, 2'b11, 2'b00};
        exp_pulses = '{1, 1, 2, 0};
        for (int m = 0; m < 4; m++) begin
            mode = modes[m];
            clear_obs();
            a[1] = 1'b1; run(12);
            n_checks++;
            if (level[1] !== 1'b1) begin
                n_fail++; $display("FAIL mode%b_rise_level: level1=%b expected 1", modes[m], level[1]);
            end
            a[1] = 1'b0; run(12);
            n_checks++;
            if (obs_pulse[1] !== exp_pulses[m] || level[1] !== 1'b0 || mism !== 0) begin
                n_fail++; $display("FAIL mode%b_pulses: pulses=%0d level1=%b model diffs=%0d expected %0d 0 0",
                                   modes[m], obs_pulse[1], level[1], mism, exp_pulses[m]);
            end
        end
    endtask

    task automatic test_simultaneous();
        mode = 2'b11;
        clear_obs();
        a[2] = 1'b1; a[5] = 1'b1;
        run(12);
        n_checks++;
        if (obs_any !== 1 || any_p !== 8'h24) begin
            n_fail++; $display("FAIL simul_same: any cycles=%0d p at any=%h expected 1 24", obs_any, any_p);
        end
        a[2] = 1'b0; a[5] = 1'b0;
        run(12);
        clear_obs();
        a[2] = 1'b1; run(2);
        a[5] = 1'b1; run(14);
        n_checks++;
        if (obs_any !== 2 || obs_pulse[2] !== 1 || obs_pulse[5] !== 1 || mism !== 0) begin
            n_fail++; $display("FAIL simul_stagger: any cycles=%0d p2=%0d p5=%0d diffs=%0d expected 2 1 1 0",
                               obs_any, obs_pulse[2], obs_pulse[5], mism);
        end
    endtask

    task automatic test_mid_reset();
        mode = 2'b01; a = '0;
        run(12);
        a = '1; run(3);
        rst = 1'b1; run(2);
        rst = 1'b0;
        clear_obs();
        run(5);
        n_checks++;
        if (obs_any !== 0) begin
            n_fail++; $display("FAIL midreset_early: any cycles=%0d expected 0", obs_any);
        end
        run(1);
        n_checks++;
        if (p !== 8'hFF || any !== 1'b1 || mism !== 0) begin
            n_fail++; $display("FAIL midreset_event: p=%h any=%b diffs=%0d expected ff 1 0", p, any, mism);
        end
    endtask

    task automatic test_random();
        int total;
        rst = 1'b1; run(2);
        rst = 1'b0;
        clear_obs();
        repeat (800) begin
            for (int i = 0; i < N; i++) if ($urandom_range(0, 5) == 0) a[i] = ~a[i];
            if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
            run(1);
        end
        total = 0;
        for (int i = 0; i < N; i++) total += obs_pulse[i];
        n_checks++;
        if (mism !== 0) begin
            n_fail++; $display("FAIL random_model: %0d diffs, first cyc %0d p=%h exp %h level=%h exp %h",
                               mism, bad_cyc, bad_p, bad_mp, bad_l, bad_ml);
        end
        n_checks++;
        if (consec !== 0) begin
            n_fail++; $display("FAIL random_consec: back-to-back pulses=%0d expected 0", consec);
        end
        n_checks++;
        if (total == 0) begin
            n_fail++; $display("FAIL random_activity: pulses=%0d expected nonzero", total);
        end
    endtask

    task automatic test_param_sweep();
        int cnt;
        mode2 = 2'b01; a2 = 1'b0; rst2 = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({level2, p2, any2} !== 3'b000) begin
            n_fail++; $display("FAIL sweep_reset: level/p/any=%b expected 000", {level2, p2, any2});
        end
        rst2 = 1'b0; a2 = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            @(negedge clk);
            n_checks++;
            if (p2 !== 1'(e == 4) || any2 !== 1'(e == 4) || level2 !== 1'(e >= 4)) begin
                n_fail++; $display("FAIL sweep_edge%0d: p=%b any=%b level=%b expected %b %b %b",
                                   e, p2, any2, level2, e == 4, e == 4, e >= 4);
            end
        end
        a2 = 1'b0;
        repeat (6) @(negedge clk);
        n_checks++;
        if (level2 !== 1'b0) begin
            n_fail++; $display("FAIL sweep_fall: level=%b expected 0", level2);
        end
        a2 = 1'b1;
        @(negedge clk);
        a2 = 1'b0;
        cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (p2 === 1'b1) cnt++;
        end
        n_checks++;
        if (cnt !== 1 || level2 !== 1'b0) begin
            n_fail++; $display("FAIL sweep_glitch: pulses=%0d level=%b expected 1 0", cnt, level2);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_latency();
        test_glitch();
        test_modes();
        test_simultaneous();
        test_mid_reset();
        test_random();
        test_param_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
